// File: rtl/qf_rfm_fifo_ctl.sv
// qf_rfm_fifo_ctl
//   Synchronous FIFO controller using an external register-file memory as
//   storage. Words arrive on a valid/ready push port and are written to the
//   memory through a registered write port. Words leave on a registered
//   valid/ready pop port that is refilled from the combinational memory read
//   port. Total capacity is DEPTH storage words plus one output-register word.
//
//   Optional feature macro: QF_RFM_FIFO_STATUS_EN adds the fifo_level and
//   fifo_afull status outputs and the PAR_AFULL_LEVEL parameter.
//
// Ports
//   rfm_clk      clock; controller on posedge, memory writes on negedge
//   rfm_rst      synchronous active-high reset
//   fifo_flush   synchronous clear of pointers and output stage
//   s_valid/s_ready/s_data   push port
//   m_valid/m_ready/m_data   pop port (m_data registered)
//   rfm_wr_en/rfm_wr_addr/rfm_wr_data   registered memory write port
//   rfm_rd_addr/rfm_rd_data             memory read port (read data is combinational)
//   fifo_level/fifo_afull               occupancy status (QF_RFM_FIFO_STATUS_EN only)
module qf_rfm_fifo_ctl #(
   parameter int PAR_MEMORY_WIDTH_BIT = 64,
   parameter int PAR_MEMORY_DEPTH_BIT = 4
`ifdef QF_RFM_FIFO_STATUS_EN
   ,parameter int PAR_AFULL_LEVEL     = (1 << PAR_MEMORY_DEPTH_BIT) - 2
`endif
) (
   input  logic                            rfm_clk,
   input  logic                            rfm_rst,
   input  logic                            fifo_flush,
   input  logic                            s_valid,
   input  logic [PAR_MEMORY_WIDTH_BIT-1:0] s_data,
   output logic                            s_ready,
   output logic                            m_valid,
   output logic [PAR_MEMORY_WIDTH_BIT-1:0] m_data,
   input  logic                            m_ready,
   output logic                            rfm_wr_en,
   output logic [PAR_MEMORY_DEPTH_BIT-1:0] rfm_wr_addr,
   output logic [PAR_MEMORY_WIDTH_BIT-1:0] rfm_wr_data,
   output logic [PAR_MEMORY_DEPTH_BIT-1:0] rfm_rd_addr,
   input  logic [PAR_MEMORY_WIDTH_BIT-1:0] rfm_rd_data
`ifdef QF_RFM_FIFO_STATUS_EN
   ,output logic [PAR_MEMORY_DEPTH_BIT+1:0] fifo_level,
   output logic                            fifo_afull
`endif
);

   localparam int AW = PAR_MEMORY_DEPTH_BIT;
   localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   out_state_t    out_state, out_state_nxt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   st_cnt;
   logic [AW:0]   st_cnt_vis;
   logic          wr_pend;     // last registered write is counted in st_cnt
   logic          push, pop, take, refill, bypass;

   always_comb begin
      s_ready       = (st_cnt < DEPTH_CNT) && !fifo_flush;
      m_valid       = (out_state == OUT_FULL);
      push          = s_valid && s_ready;
      pop           = m_valid && m_ready;
      take          = (out_state == OUT_EMPTY) || pop;
      // A word whose write is still pending is not yet read back from memory.
      st_cnt_vis    = st_cnt - {{AW{1'b0}}, wr_pend};
      refill        = take && (st_cnt_vis != '0);
      // Empty storage: route the incoming word straight to the output register.
      // Its memory write still happens but both pointers step past it.
      bypass        = take && push && (st_cnt == '0);
      out_state_nxt = out_state;
      if (refill || bypass) begin
         out_state_nxt = OUT_FULL;
      end else if (pop) begin
         out_state_nxt = OUT_EMPTY;
      end
   end

   always_ff @(posedge rfm_clk) begin
      if (rfm_rst || fifo_flush) begin
         out_state <= OUT_EMPTY;
      end else begin
         out_state <= out_state_nxt;
      end
   end

   always_ff @(posedge rfm_clk) begin
      if (rfm_rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         st_cnt      <= '0;
         wr_pend     <= 1'b0;
         m_data      <= '0;
         rfm_wr_en   <= 1'b0;
         rfm_wr_addr <= '0;
         rfm_wr_data <= '0;
      end else if (fifo_flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         st_cnt    <= '0;
         wr_pend   <= 1'b0;
         rfm_wr_en <= 1'b0;
      end else begin
         rfm_wr_en <= push;
         wr_pend   <= push && !bypass;
         if (push) begin
            rfm_wr_addr <= wr_ptr;
            rfm_wr_data <= s_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (refill) begin
            m_data <= rfm_rd_data;
         end else if (bypass) begin
            m_data <= s_data;
         end
         if (refill || bypass) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !bypass && !refill) begin
            st_cnt <= st_cnt + 1'b1;
         end else if (refill && !push) begin
            st_cnt <= st_cnt - 1'b1;
         end
      end
   end

   assign rfm_rd_addr = rd_ptr;

`ifdef QF_RFM_FIFO_STATUS_EN
   localparam int LW = AW + 2;
   localparam logic [LW-1:0] AFULL_LVL = LW'(PAR_AFULL_LEVEL);

   assign fifo_level = {1'b0, st_cnt} + {{(AW+1){1'b0}}, m_valid};
   assign fifo_afull = (fifo_level >= AFULL_LVL);
`endif

endmodule

// File: tb/tb_qf_rfm_fifo_ctl.sv
// tb_qf_rfm_fifo_ctl
//   Bench for qf_rfm_fifo_ctl with a behavioural negedge-write memory, a
//   queue-based reference model compared every cycle, and directed stimulus
//   with hand-computed literal expectations.
module tb_qf_rfm_fifo_ctl;

   localparam int W     = 64;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst, flush, s_valid, s_ready, m_valid, m_ready, wr_en;
   logic [W-1:0]  s_data, m_data, wr_data, rd_data;
   logic [AW-1:0] wr_addr, rd_addr;
`ifdef QF_RFM_FIFO_STATUS_EN
   logic [AW+1:0] lvl;
   logic          afull;
`endif

   always #5 clk = ~clk;

   qf_rfm_fifo_ctl #(
      .PAR_MEMORY_WIDTH_BIT(W),
      .PAR_MEMORY_DEPTH_BIT(AW)
   ) dut (
      .rfm_clk    (clk),
      .rfm_rst    (rst),
      .fifo_flush (flush),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .rfm_wr_en  (wr_en),
      .rfm_wr_addr(wr_addr),
      .rfm_wr_data(wr_data),
      .rfm_rd_addr(rd_addr),
      .rfm_rd_data(rd_data)
`ifdef QF_RFM_FIFO_STATUS_EN
      ,.fifo_level(lvl),
      .fifo_afull (afull)
`endif
   );

   // Register-file memory: writes on negedge, combinational read.
   logic [W-1:0] mem [DEPTH];
   always @(negedge clk) if (wr_en) mem[wr_addr] <= wr_data;
   assign rd_data = mem[rd_addr];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: storage as a queue of words, one output register.
   logic [W-1:0] q[$];
   bit           pend    = 0;
   bit           e_valid = 0;
   logic [W-1:0] e_data  = '0;
   bit           e_wen   = 0;
   logic [AW-1:0] e_waddr = '0;
   logic [W-1:0] e_wdata = '0;
   int unsigned  n_wr = 0, n_rd = 0;
   bit           started = 0;
   bit           m_push, m_pop, m_take, m_byp;
   int           m_vis;

   initial begin
      forever begin
         @(negedge clk);
         if (started && !rst)
            chk("s_ready", s_ready, (q.size() < DEPTH) && !flush);
         @(posedge clk);
         if (rst) begin
            q.delete(); pend = 0; e_valid = 0; e_data = '0;
            e_wen = 0; e_waddr = '0; e_wdata = '0; n_wr = 0; n_rd = 0;
            started = 1;
         end else if (flush) begin
            q.delete(); pend = 0; e_valid = 0; e_wen = 0; n_wr = 0; n_rd = 0;
         end else begin
            m_push = s_valid && (q.size() < DEPTH);
            m_pop  = e_valid && m_ready;
            m_take = !e_valid || m_pop;
            m_vis  = q.size() - int'(pend);
            m_byp  = 0;
            if (m_take && m_vis > 0) begin
               e_data = q.pop_front(); e_valid = 1; n_rd++;
            end else if (m_take && m_push && q.size() == 0) begin
               e_data = s_data; e_valid = 1; n_rd++; m_byp = 1;
            end else if (m_pop) begin
               e_valid = 0;
            end
            if (m_push) begin
               if (!m_byp) q.push_back(s_data);
               e_waddr = n_wr[AW-1:0];
               e_wdata = s_data;
               n_wr++;
            end
            pend  = m_push && !m_byp;
            e_wen = m_push;
         end
         #1;
         if (started) begin
            chk("m_valid", m_valid, e_valid);
            chk("m_data", m_data, e_data);
            chk("wr_en", wr_en, e_wen);
            chk("wr_addr", wr_addr, e_waddr);
            chk("wr_data", wr_data, e_wdata);
            chk("rd_addr", rd_addr, n_rd % DEPTH);
`ifdef QF_RFM_FIFO_STATUS_EN
            chk("level", lvl, q.size() + int'(e_valid));
            chk("afull", afull, (q.size() + int'(e_valid)) >= DEPTH - 2);
`endif
         end
      end
   end

   task automatic cyc(input logic v, input logic [W-1:0] d, input logic mr, input logic fl);
      s_valid = v; s_data = d; m_ready = mr; flush = fl;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      rst = 1'b0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_s_ready", s_ready, 1);

      // First word into empty FIFO
      cyc(1, 64'hA5, 0, 0);
      chk("t1_m_valid", m_valid, 1);
      chk("t1_m_data", m_data, 64'hA5);
      chk("t1_s_ready", s_ready, 1);
      cyc(0, 0, 1, 0);
      chk("t1_drain", m_valid, 0);

      // Fill to DEPTH+1, then one held-off push
      for (int i = 0; i < 17; i++) cyc(1, W'(i), 0, 0);
      chk("t2_s_ready", s_ready, 0);
`ifdef QF_RFM_FIFO_STATUS_EN
      chk("t2_level", lvl, 17);
      chk("t2_afull", afull, 1);
`endif
      cyc(1, 64'd17, 0, 0);
      chk("t2_held_m_data", m_data, 0);
      chk("t2_held_s_ready", s_ready, 0);

      // Drain in order, one per cycle
      for (int i = 0; i < 17; i++) begin
         chk("t3_m_valid", m_valid, 1);
         chk("t3_m_data", m_data, W'(i));
         cyc(0, 0, 1, 0);
      end
      chk("t3_empty", m_valid, 0);
      cyc(0, 0, 1, 0);
      chk("t3_no_extra", m_valid, 0);
      chk("t3_rd_addr", rd_addr, 2);

      // Streaming push+pop across pointer wraps
      for (int i = 0; i < 40; i++) begin
         cyc(1, W'(100 + i), 1, 0);
         chk("t4_m_valid", m_valid, 1);
         chk("t4_m_data", m_data, W'(100 + i));
      end
      cyc(0, 0, 1, 0);

      // Flush with a push while holding 5 words
      for (int i = 0; i < 5; i++) cyc(1, W'(200 + i), 0, 0);
      cyc(1, 64'h77, 0, 1);
      flush = 1'b0;
      #1;
      chk("t5_m_valid", m_valid, 0);
      chk("t5_wr_en", wr_en, 0);
      chk("t5_s_ready", s_ready, 1);
      cyc(1, 64'h3C, 0, 0);
      chk("t5_first_out", m_data, 64'h3C);
      chk("t5_first_valid", m_valid, 1);
      cyc(0, 0, 1, 0);

      // Mixed push/pop pattern (exercises pending-write refill gaps)
      for (int i = 0; i < 60; i++)
         cyc((i % 5) != 1, W'(300 + i), (i % 3) != 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);
      chk("t6_empty", m_valid, 0);

      // Reset mid-burst
      for (int i = 0; i < 6; i++) cyc(1, W'(400 + i), 0, 0);
      rst = 1'b1;
      cyc(1, 64'h99, 0, 0);
      rst = 1'b0;
      chk("t7_m_valid", m_valid, 0);
      chk("t7_m_data", m_data, 0);
      chk("t7_wr_en", wr_en, 0);
      chk("t7_wr_addr", wr_addr, 0);
      chk("t7_rd_addr", rd_addr, 0);
      cyc(1, 64'h55, 0, 0);
      chk("t7_wr_en_after", wr_en, 1);
      chk("t7_wr_addr_after", wr_addr, 0);
      chk("t7_m_data_after", m_data, 64'h55);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/qf_rfm_fifo_ctl.md
# qf_rfm_fifo_ctl

Synchronous FIFO controller that wraps the FCB register-file memory as FIFO storage. It accepts words on a valid/ready push port, drives the memory write port and read address, and presents words on a registered valid/ready pop port. It sits between the FCB configuration-data source and the downstream bitstream consumer, with the register-file memory instantiated alongside as its storage.

## Interface
- PAR_MEMORY_WIDTH_BIT, 64: data word width; must match the attached memory.
- PAR_MEMORY_DEPTH_BIT, 4: address width; storage depth DEPTH = 2**PAR_MEMORY_DEPTH_BIT.
- PAR_AFULL_LEVEL, DEPTH-2: almost-full threshold on total occupancy. Used only with QF_RFM_FIFO_STATUS_EN.
- rfm_clk  in  1  single clock. Controller logic is posedge. The memory writes on negedge.
- rfm_rst  in  1  synchronous, active-high reset.
- fifo_flush  in  1  synchronous clear of pointers and output stage. Memory contents are untouched.
- s_valid  in  1  push request.
- s_data  in  PAR_MEMORY_WIDTH_BIT  push data.
- s_ready  out  1  push accepted when s_valid && s_ready at a posedge.
- m_valid  out  1  output word valid.
- m_data  out  PAR_MEMORY_WIDTH_BIT  output word, registered.
- m_ready  in  1  pop accepted when m_valid && m_ready at a posedge.
- rfm_wr_en  out  1  memory write enable, registered.
- rfm_wr_addr  out  PAR_MEMORY_DEPTH_BIT  memory write address, registered.
- rfm_wr_data  out  PAR_MEMORY_WIDTH_BIT  memory write data, registered.
- rfm_rd_addr  out  PAR_MEMORY_DEPTH_BIT  memory read address, equal to rd_ptr.
- rfm_rd_data  in  PAR_MEMORY_WIDTH_BIT  combinational memory read data.
- fifo_level  out  PAR_MEMORY_DEPTH_BIT+2  total occupancy (storage plus output register). Present only with QF_RFM_FIFO_STATUS_EN.
- fifo_afull  out  1  high when fifo_level >= PAR_AFULL_LEVEL. Present only with QF_RFM_FIFO_STATUS_EN.

## Operation
- State:
  - wr_ptr, rd_ptr: PAR_MEMORY_DEPTH_BIT bits each; wrap modulo DEPTH.
  - st_cnt: PAR_MEMORY_DEPTH_BIT+1 bits, range 0..DEPTH.
  - Output stage: two states, OUT_EMPTY (m_valid=0) and OUT_FULL (m_valid=1).
- s_ready = (st_cnt < DEPTH) && !fifo_flush. It is combinational from registers and fifo_flush only, with no path from s_valid.
- Push (s_valid && s_ready) at posedge k:
  - Register rfm_wr_en=1, rfm_wr_addr=wr_ptr, rfm_wr_data=s_data.
  - wr_ptr += 1.
  - The memory captures the word at the negedge inside cycle k+1.
- Refill condition: (OUT_EMPTY || pop) && st_cnt_visible > 0.
  - st_cnt_visible excludes a word whose write is still pending, i.e. one with rfm_wr_en registered high this cycle.
  - On refill: m_data <= rfm_rd_data, rd_ptr += 1, state becomes OUT_FULL.
- Pop without refill: state becomes OUT_EMPTY. m_data holds its last value.
- st_cnt update: st_cnt += push − refill. Simultaneous push and refill leaves st_cnt unchanged.
- Full storage: s_ready=0 and the push is not accepted. Total capacity is DEPTH+1 words.
- Empty storage with a pop: m_valid drops the next cycle. No underflow read occurs; rd_ptr is unchanged.
- Ordering: strict FIFO order across pointer wrap.
- fifo_flush has priority over push and pop. Values on the next posedge:
  - pointers = 0, st_cnt = 0, OUT_EMPTY.
  - rfm_wr_en = 0; a push presented in that cycle is dropped.
- Reset values: all identical to flush. Additionally m_data=0, rfm_wr_addr=0, rfm_wr_data=0, rfm_wr_en=0.
- Reset mid-operation: all words are discarded. No memory write is issued in the cycle after reset.

## Timing
- Push-to-m_valid latency:
  - 1 cycle for the first word into an empty FIFO: push at posedge k, memory write at negedge, m_valid=1 after posedge k+1.
  - 2 cycles is acceptable only via the pending-write exclusion. Implementation must achieve 1 cycle by bypassing s_data directly into m_data when st_cnt==0 and the output stage is empty or popping.
- Bypass rule: the word still goes through the memory write, and the write is discarded logically (wr_ptr and rd_ptr both advance).
- Sustained throughput: 1 push and 1 pop per cycle with no bubbles.
- s_ready returns high the cycle after a refill frees a storage slot.

## Configuration
- QF_RFM_FIFO_STATUS_EN defined:
  - fifo_level = st_cnt + m_valid, registered-equivalent (derived from registers only).
  - fifo_afull is compared against PAR_AFULL_LEVEL.
  - Both ports reset to 0.
- Undefined: fifo_level and fifo_afull ports and their logic are absent. Core behaviour is identical.

## Test plan
- Reset, then push 0xA5 once with m_ready=0 -> m_valid=1 with m_data=0xA5 one cycle after the push. s_ready stays 1.
- DEPTH=16, m_ready=0, push 17 words 0..16 -> all 17 accepted. s_ready=0 after the 17th. fifo_level=17. An 18th push is held off.
- From full, m_ready=1 continuously -> outputs 0..16 in order, one per cycle. m_valid drops after word 16. No extra pops.
- Continuous push and pop for 40 words -> no bubbles, order preserved across two pointer wraps, st_cnt constant.
- fifo_flush asserted together with a push while holding 5 words -> next cycle m_valid=0, s_ready=1, rfm_wr_en=0. The next push of 0x3C appears as the first output.
- rfm_rst asserted mid-burst -> all outputs return to reset values on the next posedge. Subsequent traffic starts at address 0.
